// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32I control FSM with memory handshake, timeout and instret
module mc_ctrl_fsm #(
  parameter int CNT_W           = 32,
  parameter int MEM_TIMEOUT     = 0,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             alu_bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic             illegal_instr,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_PCINC = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // The counter only needs to reach MEM_TIMEOUT-1: the next idle cycle aborts.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;
  logic              retire;
  logic              set_illegal;
  logic              set_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IF;
      wait_cnt      <= '0;
      instret       <= '0;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if ((state == S_IF || state == S_MEM) && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
      if (set_illegal) begin
        illegal_instr <= 1'b1;
      end
      if (set_timeout) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n       = state;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    wb_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    is_halted     = 1'b0;
    timed_out     = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == WAIT_LAST);

    // Outputs are forced low for the whole time reset is held.
    if (reset) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_n  = S_ID;
          end else if (timed_out) begin
            set_timeout = 1'b1;
            state_n     = S_HALT;
          end
        end
        S_ID: begin
          alu_src_b = 2'b10;
          if (opcode == OP_ECALL) begin
            state_n = halt_req ? S_HALT : S_PCINC;
          end else begin
            state_n = S_EX;
          end
        end
        S_EX: begin
          case (opcode)
            OP_R: begin
              alu_src_a = 1'b1;
              alu_op    = 2'b10;
              state_n   = S_WB;
            end
            OP_I: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_op    = 2'b10;
              state_n   = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              state_n   = S_MEM;
            end
            OP_BRANCH: begin
              alu_src_a     = 1'b1;
              alu_op        = 2'b01;
              pc_write_cond = 1'b1;
              pc_source     = 1'b1;
              if (alu_bcond) begin
                retire  = 1'b1;
                state_n = S_IF;
              end else begin
                state_n = S_PCINC;
              end
            end
            OP_JAL: begin
              reg_write = 1'b1;
              wb_src    = 2'b10;
              pc_write  = 1'b1;
              pc_source = 1'b1;
              retire    = 1'b1;
              state_n   = S_IF;
            end
            OP_JALR: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              reg_write = 1'b1;
              wb_src    = 2'b10;
              pc_write  = 1'b1;
              retire    = 1'b1;
              state_n   = S_IF;
            end
            default: begin
              if (HALT_ON_ILLEGAL) begin
                set_illegal = 1'b1;
                state_n     = S_HALT;
              end else begin
                state_n = S_PCINC;
              end
            end
          endcase
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (opcode == OP_LOAD) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          if (mem_ready) begin
            state_n = (opcode == OP_LOAD) ? S_WB : S_PCINC;
          end else if (timed_out) begin
            set_timeout = 1'b1;
            state_n     = S_HALT;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_src    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          retire    = 1'b1;
          state_n   = S_IF;
        end
        S_PCINC: begin
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          retire    = 1'b1;
          state_n   = S_IF;
        end
        S_HALT: begin
          is_halted = 1'b1;
        end
        default: begin
          state_n = S_IF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm (default and timeout/NOP-on-illegal builds)
module tb_mc_ctrl_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       halt_req;
  logic       mem_ready;

  logic        pcw_a, pcwc_a, pcs_a, iod_a, mr_a, mw_a, irw_a, rw_a, a_a, h_a, ill_a, to_a;
  logic [1:0]  wb_a, b_a, op_a;
  logic [31:0] inst_a;
  logic        pcw_b, pcwc_b, pcs_b, iod_b, mr_b, mw_b, irw_b, rw_b, a_b, h_b, ill_b, to_b;
  logic [1:0]  wb_b, b_b, op_b;
  logic [31:0] inst_b;

  // dut_a: no timeout, halt on illegal; dut_b: MEM_TIMEOUT=4, illegal is a NOP
  mc_ctrl_fsm #(.CNT_W(32), .MEM_TIMEOUT(0), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .pc_write(pcw_a), .pc_write_cond(pcwc_a), .pc_source(pcs_a),
    .i_or_d(iod_a), .mem_read(mr_a), .mem_write(mw_a), .ir_write(irw_a), .reg_write(rw_a),
    .wb_src(wb_a), .alu_src_a(a_a), .alu_src_b(b_a), .alu_op(op_a), .is_halted(h_a),
    .illegal_instr(ill_a), .mem_timeout(to_a), .instret(inst_a)
  );

  mc_ctrl_fsm #(.CNT_W(32), .MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .pc_write(pcw_b), .pc_write_cond(pcwc_b), .pc_source(pcs_b),
    .i_or_d(iod_b), .mem_read(mr_b), .mem_write(mw_b), .ir_write(irw_b), .reg_write(rw_b),
    .wb_src(wb_b), .alu_src_a(a_b), .alu_src_b(b_b), .alu_op(op_b), .is_halted(h_b),
    .illegal_instr(ill_b), .mem_timeout(to_b), .instret(inst_b)
  );

  always #5 clk = ~clk;

  logic [17:0] obs_a, obs_b;
  assign obs_a = {pcw_a, pcwc_a, pcs_a, iod_a, mr_a, mw_a, irw_a, rw_a, wb_a, a_a, b_a, op_a, h_a, ill_a, to_a};
  assign obs_b = {pcw_b, pcwc_b, pcs_b, iod_b, mr_b, mw_b, irw_b, rw_b, wb_b, a_b, b_b, op_b, h_b, ill_b, to_b};

  typedef struct packed {
    logic [17:0] ea;
    logic [17:0] eb;
    logic [31:0] ia;
    logic [31:0] ib;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  cur;
  string cur_tag;
  int    n_run  = 0;
  int    n_fail = 0;
  logic [31:0] ia = 0;
  logic [31:0] ib = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] cw(input logic pcw, pcwc, pcs, iod, mr, mw, irw, rw,
                                     input logic [1:0] wb, input logic a, input logic [1:0] b,
                                     input logic [1:0] op, input logic h, ill, to);
    return {pcw, pcwc, pcs, iod, mr, mw, irw, rw, wb, a, b, op, h, ill, to};
  endfunction

  function automatic logic [17:0] f_zero();           return 18'd0; endfunction
  function automatic logic [17:0] f_if(input logic irw);
    return cw(0,0,0,0,1,0,irw,0,2'b00,0,2'b00,2'b00,0,0,0);
  endfunction
  function automatic logic [17:0] f_id();    return cw(0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00,0,0,0); endfunction
  function automatic logic [17:0] f_ex_r();  return cw(0,0,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0); endfunction
  function automatic logic [17:0] f_ex_i();  return cw(0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b10,0,0,0); endfunction
  function automatic logic [17:0] f_ex_ls(); return cw(0,0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0); endfunction
  function automatic logic [17:0] f_ex_br(); return cw(0,1,1,0,0,0,0,0,2'b00,1,2'b00,2'b01,0,0,0); endfunction
  function automatic logic [17:0] f_jal();   return cw(1,0,1,0,0,0,0,1,2'b10,0,2'b00,2'b00,0,0,0); endfunction
  function automatic logic [17:0] f_jalr();  return cw(1,0,0,0,0,0,0,1,2'b10,1,2'b10,2'b00,0,0,0); endfunction
  function automatic logic [17:0] f_pcinc(); return cw(1,0,0,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0); endfunction
  function automatic logic [17:0] f_mem(input logic ld);
    return cw(0,0,0,1,ld,~ld,0,0,2'b00,0,2'b00,2'b00,0,0,0);
  endfunction
  function automatic logic [17:0] f_wb(input logic ld);
    return cw(1,0,0,0,0,0,0,1,ld ? 2'b01 : 2'b00,0,2'b01,2'b00,0,0,0);
  endfunction
  function automatic logic [17:0] f_halt(input logic ill, input logic to);
    return cw(0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,ill,to);
  endfunction

  // Drive one cycle of stimulus and queue what both DUTs must show in it.
  task automatic cyc(input string tag, input logic mr, input logic [17:0] ea, input logic [17:0] eb);
    exp_t e;
    mem_ready = mr;
    e.ea = ea;
    e.eb = eb;
    e.ia = ia;
    e.ib = ib;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [6:0] op);
    opcode = op;
    cyc({tag, "_if"}, 1'b1, f_if(1'b1), f_if(1'b1));
    cyc({tag, "_id"}, 1'b1, f_id(), f_id());
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur     = exp_q.pop_front();
      cur_tag = tag_q.pop_front();
      check({cur_tag, ".ctl_a"}, {14'd0, obs_a}, {14'd0, cur.ea});
      check({cur_tag, ".ctl_b"}, {14'd0, obs_b}, {14'd0, cur.eb});
      check({cur_tag, ".ret_a"}, inst_a, cur.ia);
      check({cur_tag, ".ret_b"}, inst_b, cur.ib);
    end
  end

  initial begin
    reset = 1'b0; opcode = 7'd0; alu_bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst0", 1'b1, f_zero(), f_zero());
    cyc("rst1", 1'b1, f_zero(), f_zero());
    reset = 1'b1;

    fetch("r", OP_R);
    cyc("r_ex", 1'b1, f_ex_r(), f_ex_r());
    cyc("r_wb", 1'b0, f_wb(1'b0), f_wb(1'b0));
    ia++; ib++;

    fetch("ld", OP_LOAD);
    cyc("ld_ex", 1'b0, f_ex_ls(), f_ex_ls());
    for (int i = 0; i < 3; i++) cyc("ld_memw", 1'b0, f_mem(1'b1), f_mem(1'b1));
    cyc("ld_memr", 1'b1, f_mem(1'b1), f_mem(1'b1));
    cyc("ld_wb", 1'b0, f_wb(1'b1), f_wb(1'b1));
    ia++; ib++;

    fetch("st", OP_STORE);
    cyc("st_ex", 1'b1, f_ex_ls(), f_ex_ls());
    cyc("st_mem", 1'b1, f_mem(1'b0), f_mem(1'b0));
    cyc("st_pci", 1'b1, f_pcinc(), f_pcinc());
    ia++; ib++;

    alu_bcond = 1'b1;
    fetch("bt", OP_BRANCH);
    cyc("bt_ex", 1'b1, f_ex_br(), f_ex_br());
    ia++; ib++;
    alu_bcond = 1'b0;
    fetch("bn", OP_BRANCH);
    cyc("bn_ex", 1'b1, f_ex_br(), f_ex_br());
    alu_bcond = 1'b1;
    cyc("bn_pci", 1'b0, f_pcinc(), f_pcinc());
    ia++; ib++;
    alu_bcond = 1'b0;

    opcode = OP_I;
    cyc("i_ifw", 1'b0, f_if(1'b0), f_if(1'b0));
    cyc("i_ifw", 1'b0, f_if(1'b0), f_if(1'b0));
    cyc("i_ifr", 1'b1, f_if(1'b1), f_if(1'b1));
    cyc("i_id", 1'b0, f_id(), f_id());
    cyc("i_ex", 1'b0, f_ex_i(), f_ex_i());
    cyc("i_wb", 1'b0, f_wb(1'b0), f_wb(1'b0));
    ia++; ib++;

    fetch("jal", OP_JAL);
    cyc("jal_ex", 1'b0, f_jal(), f_jal());
    ia++; ib++;
    fetch("jalr", OP_JALR);
    cyc("jalr_ex", 1'b0, f_jalr(), f_jalr());
    ia++; ib++;

    halt_req = 1'b0;
    fetch("ec0", OP_ECALL);
    cyc("ec0_pci", 1'b0, f_pcinc(), f_pcinc());
    ia++; ib++;

    fetch("ill", 7'b0000000);
    cyc("ill_ex", 1'b0, f_zero(), f_zero());
    cyc("ill_h", 1'b0, f_halt(1'b1, 1'b0), f_pcinc());
    ib++;
    for (int i = 0; i < 4; i++) cyc("to_ifw", 1'b0, f_halt(1'b1, 1'b0), f_if(1'b0));
    for (int i = 0; i < 6; i++) cyc("to_halt", i[0], f_halt(1'b1, 1'b0), f_halt(1'b0, 1'b1));

    reset = 1'b0;
    ia = 0; ib = 0;
    cyc("rst2", 1'b1, f_zero(), f_zero());
    reset = 1'b1;

    opcode = OP_R;
    for (int i = 0; i < 3; i++) cyc("lim_ifw", 1'b0, f_if(1'b0), f_if(1'b0));
    cyc("lim_ifr", 1'b1, f_if(1'b1), f_if(1'b1));
    cyc("lim_id", 1'b0, f_id(), f_id());
    cyc("lim_ex", 1'b0, f_ex_r(), f_ex_r());
    cyc("lim_wb", 1'b0, f_wb(1'b0), f_wb(1'b0));
    ia++; ib++;

    halt_req = 1'b1;
    fetch("ec1", OP_ECALL);
    halt_req = 1'b0;
    for (int i = 0; i < 20; i++) cyc("ec1_halt", i[0], f_halt(1'b0, 1'b0), f_halt(1'b0, 1'b0));

    reset = 1'b0;
    ia = 0; ib = 0;
    cyc("rst3", 1'b1, f_zero(), f_zero());
    reset = 1'b1;

    fetch("ab", OP_LOAD);
    cyc("ab_ex", 1'b0, f_ex_ls(), f_ex_ls());
    cyc("ab_memw", 1'b0, f_mem(1'b1), f_mem(1'b1));
    reset = 1'b0;
    cyc("ab_rst", 1'b0, f_zero(), f_zero());
    cyc("ab_rst", 1'b1, f_zero(), f_zero());

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
